// File: rtl/sine_nco_pkg.sv
// Shared widths, divider floor and dither LFSR constants for the sine NCO.
// Pure declarations; no logic, no latency, no flow control.
// Imported by sine_nco and sine_nco_lfsr.
package sine_nco_pkg;

    localparam int PHASE_W_DEF = 16;
    localparam int ADDR_W_DEF  = 4;
    localparam int DATA_W_DEF  = 8;
    localparam int DIV_W_DEF   = 16;

    // Three-cycle floor keeps each capture clear of the next issue.
    localparam int MIN_DIV = 2;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // Fibonacci taps 8,6,5,4 -> bits 7,5,4,3.
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    typedef logic [PHASE_W_DEF-1:0] phase_t;

endpackage

// File: rtl/sine_nco_lfsr.sv
// 8-bit Fibonacci LFSR supplying address dither to the NCO.
// Advances one step per cycle with adv_i high; value is registered.
// No backpressure; the caller decides when to step it.
module sine_nco_lfsr
    import sine_nco_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       adv_i,
    output logic [7:0] lfsr_o
);

    logic [7:0] lfsr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= LFSR_SEED;
        end else if (adv_i) begin
            lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/sine_nco.sv
// Sine NCO: phase accumulator driving a 16-entry RAM; optional dither under SINE_NCO_DITHER_EN.
// Latency: rom_cen_o in cycle T gives sample_valid_o in cycle T+2.
// Backpressure: a sample arriving while the held one is unaccepted is dropped and sets overrun_o.
module sine_nco
    import sine_nco_pkg::*;
#(
    parameter int PHASE_W = PHASE_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DIV_W   = DIV_W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic [DIV_W-1:0]   sample_div_i,
    input  logic [PHASE_W-1:0] tw_i,
    input  logic               tw_valid_i,
    output logic               tw_ready_o,
    output logic               rom_cen_o,
    output logic [ADDR_W-1:0]  rom_addr_o,
    input  logic [DATA_W-1:0]  rom_data_i,
    output logic [DATA_W-1:0]  sample_o,
    output logic               sample_valid_o,
    input  logic               sample_ready_i,
    input  logic               overrun_clr_i,
    output logic               overrun_o
);

    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] tw_reg;
    logic [DIV_W-1:0]   cnt;
    logic [DIV_W-1:0]   div_eff;
    logic               tick_q;
    logic               issue_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  sample_q;
    logic               sample_vld_q;
    logic               overrun_q;
    logic [PHASE_W-1:0] addr_phase;
    logic               commit;

    assign div_eff = (sample_div_i < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : sample_div_i;

`ifdef SINE_NCO_DITHER_EN
    logic [7:0] lfsr;

    sine_nco_lfsr u_lfsr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .adv_i  (tick_q),
        .lfsr_o (lfsr)
    );

    // Dither shapes the address only; the accumulator stays exact.
    assign addr_phase = phase + PHASE_W'(lfsr);
`else
    assign addr_phase = phase;
`endif

    // The RAM output is committed in the capture cycle itself so a sample lands at T+2.
    assign commit = issue_q && (!sample_vld_q || sample_ready_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase        <= '0;
            tw_reg       <= '0;
            cnt          <= '0;
            tick_q       <= 1'b0;
            issue_q      <= 1'b0;
            addr_q       <= '0;
            sample_q     <= '0;
            sample_vld_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if (en_i) begin
                if (cnt >= div_eff) begin
                    cnt    <= '0;
                    tick_q <= 1'b1;
                    // Phase cannot move at this edge, so this is the pre-increment address.
                    addr_q <= addr_phase[PHASE_W-1 -: ADDR_W];
                end else begin
                    cnt    <= cnt + DIV_W'(1);
                    tick_q <= 1'b0;
                end
            end else begin
                tick_q <= 1'b0;
            end

            if (tick_q) begin
                phase <= phase + tw_reg;
            end
            issue_q <= tick_q;

            if (tw_valid_i && !tick_q) begin
                tw_reg <= tw_i;
            end

            if (commit) begin
                sample_q     <= rom_data_i;
                sample_vld_q <= 1'b1;
            end else if (sample_vld_q && sample_ready_i) begin
                sample_vld_q <= 1'b0;
            end

            if (issue_q && !commit) begin
                overrun_q <= 1'b1;
            end else if (overrun_clr_i) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign tw_ready_o     = !tick_q;
    assign rom_cen_o      = tick_q;
    assign rom_addr_o     = addr_q;
    assign sample_o       = sample_q;
    assign sample_valid_o = sample_vld_q;
    assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_sine_nco.sv
// Scoreboard bench for sine_nco: stimulus queues expected addresses/samples, a monitor pops on each strobe/transfer.
module tb_sine_nco;
    import sine_nco_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        en_i;
    logic [15:0] sample_div_i;
    logic [15:0] tw_i;
    logic        tw_valid_i;
    logic        tw_ready_o;
    logic        rom_cen_o;
    logic [3:0]  rom_addr_o;
    logic [7:0]  rom_data_i = 8'h00;
    logic [7:0]  sample_o;
    logic        sample_valid_o;
    logic        sample_ready_i;
    logic        overrun_clr_i;
    logic        overrun_o;

    int checks   = 0;
    int failures = 0;

    int exp_addr[$];
    int exp_samp[$];
    int cen_seen   = 0;
    int phase_id   = 0;
    int exp_period = 4;
    bit lat_en     = 0;

    int mon_phase  = 0;
    int cyc        = 0;
    int last_cyc   = 0;
    bit last_vld   = 0;
    bit cen_d1     = 0;
    bit cen_d2     = 0;

    sine_nco dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .en_i           (en_i),
        .sample_div_i   (sample_div_i),
        .tw_i           (tw_i),
        .tw_valid_i     (tw_valid_i),
        .tw_ready_o     (tw_ready_o),
        .rom_cen_o      (rom_cen_o),
        .rom_addr_o     (rom_addr_o),
        .rom_data_i     (rom_data_i),
        .sample_o       (sample_o),
        .sample_valid_o (sample_valid_o),
        .sample_ready_i (sample_ready_i),
        .overrun_clr_i  (overrun_clr_i),
        .overrun_o      (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [7:0] sine(input int i);
        case (i)
            0: return 8'd128;   1: return 8'd177;   2: return 8'd218;   3: return 8'd245;
            4: return 8'd255;   5: return 8'd245;   6: return 8'd218;   7: return 8'd177;
            8: return 8'd128;   9: return 8'd79;    10: return 8'd38;   11: return 8'd11;
            12: return 8'd1;    13: return 8'd11;   14: return 8'd38;   15: return 8'd79;
            default: return 8'd0;
        endcase
    endfunction

    // Registered-read RAM model.
    always @(posedge clk_i) begin
        if (rom_cen_o) rom_data_i <= sine(int'(rom_addr_o));
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int a, input bit with_samp);
        exp_addr.push_back(a);
        if (with_samp) exp_samp.push_back(int'(sine(a)));
    endtask

    // Monitor: pops expectations on every read strobe and every accepted sample.
    always @(negedge clk_i) begin
        cyc++;
        if (lat_en) check("latency_valid_vs_cen_t_minus_2", sample_valid_o, cen_d2);
        cen_d2 = cen_d1;
        cen_d1 = rom_cen_o && !rst_i;
        if (phase_id != mon_phase) begin
            mon_phase = phase_id;
            last_vld  = 0;
        end
        if (!rst_i && rom_cen_o) begin
            cen_seen++;
            if (exp_addr.size() > 0) begin
                check("rom_addr", rom_addr_o, exp_addr.pop_front());
            end else begin
                checks++;
                failures++;
                $display("FAIL unexpected_rom_cen: addr %0h with no read expected", rom_addr_o);
            end
            if (last_vld) check("issue_period", cyc - last_cyc, exp_period);
            last_cyc = cyc;
            last_vld = 1;
        end
        if (!rst_i && sample_valid_o && sample_ready_i) begin
            if (exp_samp.size() > 0) begin
                check("sample", sample_o, exp_samp.pop_front());
            end else begin
                checks++;
                failures++;
                $display("FAIL unexpected_sample: got %0h with no sample expected", sample_o);
            end
        end
    end

    task automatic load_tw(input logic [15:0] w);
        @(posedge clk_i); #1;
        tw_i       = w;
        tw_valid_i = 1'b1;
        @(posedge clk_i); #1;
        tw_valid_i = 1'b0;
    endtask

    task automatic wait_target(input int target, input string name);
        for (int i = 0; i < 400 && cen_seen < target; i++) @(posedge clk_i);
        #1 en_i = 1'b0;
        check(name, cen_seen, target);
        repeat (6) @(posedge clk_i);
    endtask

    task automatic run_issues(input int n, input string name);
        int target;
        phase_id++;
        target = cen_seen + n;
        en_i   = 1'b1;
        wait_target(target, name);
    endtask

    task automatic find_issue(input string name);
        bit found;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk_i);
            found = rom_cen_o;
        end
        check(name, found, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int target;
        int c0;
        phase_t tw_nom;
        tw_nom         = 16'h1000;
        rst_i          = 1'b1;
        en_i           = 1'b0;
        sample_div_i   = 16'd3;
        tw_i           = '0;
        tw_valid_i     = 1'b0;
        sample_ready_i = 1'b1;
        overrun_clr_i  = 1'b0;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("reset_sample_valid", sample_valid_o, 0);
        check("reset_sample", sample_o, 0);
        check("reset_overrun", overrun_o, 0);
        check("reset_rom_cen", rom_cen_o, 0);
        check("reset_rom_addr", rom_addr_o, 0);
        @(posedge clk_i); #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("reset_tw_ready", tw_ready_o, 1);

        // Nominal: 17 reads, addresses 0..15,0, period 4, valid two cycles after each strobe.
        load_tw(tw_nom);
        for (int i = 0; i < 17; i++) push(i % 16, 1);
        exp_period = 4;
        lat_en     = 1;
        run_issues(17, "nominal_issue_count");
        lat_en     = 0;

        // Divider clamp: 0 and 1 both give a 3-cycle period.
        sample_div_i = 16'd0;
        exp_period   = 3;
        for (int i = 1; i <= 4; i++) push(i, 1);
        run_issues(4, "div0_issue_count");
        sample_div_i = 16'd1;
        for (int i = 5; i <= 7; i++) push(i, 1);
        run_issues(3, "div1_issue_count");

        // Backpressure: second sample dropped, first held.
        sample_div_i   = 16'd3;
        exp_period     = 4;
        sample_ready_i = 1'b0;
        push(8, 1);
        push(9, 0);
        run_issues(2, "bp_issue_count");
        check("bp_valid_held", sample_valid_o, 1);
        check("bp_sample_held", sample_o, sine(8));
        check("bp_overrun_set", overrun_o, 1);
        @(posedge clk_i); #1;
        sample_ready_i = 1'b1;
        overrun_clr_i  = 1'b1;
        @(posedge clk_i); #1;
        overrun_clr_i  = 1'b0;
        @(negedge clk_i);
        check("bp_overrun_cleared", overrun_o, 0);
        check("bp_valid_released", sample_valid_o, 0);
        push(10, 1);
        run_issues(1, "bp_resume_issue_count");

        // Tuning change offered on an issue cycle: 11 (old word), then 12, 14, 0 with 16'h2000.
        phase_id++;
        push(11, 1);
        push(12, 1);
        push(14, 1);
        push(0, 1);
        target = cen_seen + 4;
        @(posedge clk_i); #1 en_i = 1'b1;
        find_issue("tw_issue_found");
        tw_i       = 16'h2000;
        tw_valid_i = 1'b1;
        #1 check("tw_ready_on_issue", tw_ready_o, 0);
        @(negedge clk_i);
        check("tw_ready_after_issue", tw_ready_o, 1);
        @(posedge clk_i); #1 tw_valid_i = 1'b0;
        wait_target(target, "tw_issue_count");

        // Reset in the capture cycle: read at address 2 issued, its sample never appears.
        phase_id++;
        push(2, 0);
        @(posedge clk_i); #1 en_i = 1'b1;
        find_issue("rst_issue_found");
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        en_i  = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        check("midrst_sample_valid", sample_valid_o, 0);
        check("midrst_sample", sample_o, 0);
        check("midrst_overrun", overrun_o, 0);
        check("midrst_rom_cen", rom_cen_o, 0);
        check("midrst_rom_addr", rom_addr_o, 0);
        @(posedge clk_i); #1 rst_i = 1'b0;
        c0 = cen_seen;
        repeat (20) @(posedge clk_i);
        @(negedge clk_i);
        check("disabled_no_cen", cen_seen, c0);
        check("disabled_no_valid", sample_valid_o, 0);

        // Wrap: phase reaches 16'hF000, then tw 16'h2000 gives addresses 15 then 1.
        load_tw(16'hF000);
        push(0, 1);
        run_issues(1, "wrap_setup_issue_count");
        load_tw(16'h2000);
        push(15, 1);
        push(1, 1);
        run_issues(2, "wrap_issue_count");

        check("addr_queue_drained", exp_addr.size(), 0);
        check("sample_queue_drained", exp_samp.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
